load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 170 +++++++++++++++++
 tb/tb_load_store_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit bridging the core's byte-addressed accesses to a word-wide RAM bus.
// It checks size and alignment, steers byte lanes, extends load results and aborts stalled accesses.
module load_store_unit #(
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [2:0]  funct,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        done,
   output logic        err,
   output logic        busy,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ready,
   input  logic [31:0] bus_rdata
);

   // state  | meaning
   // IDLE   | waiting for req
   // ACCESS | bus cycle in flight, waiting for bus_ready
   // RESP   | done pulse after a completed access
   // ERR    | done+err pulse after a rejected or timed-out access
   typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

   localparam int CW = $clog2(TIMEOUT + 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          we_q, we_d;
   logic [2:0]    funct_q, funct_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   rdata_q, rdata_d;

   logic          req_ok;
   logic [7:0]    lane_b;
   logic [15:0]   lane_h;
   logic [31:0]   load_val;
   logic [3:0]    store_be;
   logic [31:0]   store_data;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         funct_q <= 3'b000;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         funct_q <= funct_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Size code legality and natural alignment of the incoming request.
   always_comb begin
      req_ok = 1'b0;
      case (funct)
         3'b000:  req_ok = 1'b1;
         3'b001:  req_ok = !addr[0];
         3'b010:  req_ok = (addr[1:0] == 2'b00);
         3'b100:  req_ok = !we;
         3'b101:  req_ok = !we && !addr[0];
         default: req_ok = 1'b0;
      endcase
   end

   always_comb begin
      lane_b = bus_rdata[7:0];
      case (addr_q[1:0])
         2'd0:    lane_b = bus_rdata[7:0];
         2'd1:    lane_b = bus_rdata[15:8];
         2'd2:    lane_b = bus_rdata[23:16];
         default: lane_b = bus_rdata[31:24];
      endcase
      lane_h = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      load_val = bus_rdata;
      case (funct_q)
         3'b000:  load_val = {{24{lane_b[7]}}, lane_b};
         3'b100:  load_val = {24'h0, lane_b};
         3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
         3'b101:  load_val = {16'h0, lane_h};
         default: load_val = bus_rdata;
      endcase
   end

   always_comb begin
      store_be   = 4'b1111;
      store_data = wdata_q;
      case (funct_q[1:0])
         2'b00: begin
            store_be   = 4'b0001 << addr_q[1:0];
            store_data = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            store_be   = 4'b0011 << addr_q[1:0];
            store_data = {2{wdata_q[15:0]}};
         end
         default: begin
            store_be   = 4'b1111;
            store_data = wdata_q;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      funct_d = funct_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               if (req_ok) begin
                  we_d    = we;
                  funct_d = funct;
                  addr_d  = addr;
                  wdata_d = wdata;
                  cnt_d   = '0;
                  state_d = ACCESS;
               end else begin
                  state_d = ERR;
               end
            end
         end
         ACCESS: begin
            // bus_ready takes priority over a coincident timeout
            if (bus_ready) begin
               state_d = RESP;
               if (!we_q) rdata_d = load_val;
            end else begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_d == CW'(TIMEOUT)) state_d = ERR;
            end
         end
         RESP:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign rdata     = rdata_q;
   assign done      = (state_q == RESP) || (state_q == ERR);
   assign err       = (state_q == ERR);
   assign busy      = (state_q != IDLE);
   assign bus_req   = (state_q == ACCESS);
   assign bus_we    = (state_q == ACCESS) && we_q;
   assign bus_addr  = {addr_q[31:2], 2'b00};
   assign bus_be    = (state_q != ACCESS) ? 4'b0000 : (we_q ? store_be : 4'b1111);
   assign bus_wdata = store_data;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed corner cases plus randomized accesses
// compared against an arithmetic model of lane selection, extension and timing.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req, we;
   logic [2:0]  funct;
   logic [31:0] addr, wdata, rdata;
   logic        done, err, busy, bus_req, bus_we, bus_ready;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_be;

   int n_cmp = 0;
   int n_bad = 0;

   load_store_unit #(.TIMEOUT(15)) dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .funct(funct), .addr(addr),
      .wdata(wdata), .rdata(rdata), .done(done), .err(err), .busy(busy),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   // reference model
   bit [31:0] exp_rdata;

   function automatic bit m_legal(bit w, bit [2:0] f, bit [31:0] a);
      case (f)
         3'd0:    return 1'b1;
         3'd1:    return (a % 2) == 0;
         3'd2:    return (a % 4) == 0;
         3'd4:    return !w;
         3'd5:    return !w && ((a % 2) == 0);
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit [31:0] m_load(bit [2:0] f, bit [31:0] a, bit [31:0] word);
      int unsigned off = a % 4;
      bit [31:0] b = (word >> (8 * off)) & 32'hFF;
      bit [31:0] h = (word >> (16 * (off / 2))) & 32'hFFFF;
      case (f)
         3'd0:    return (b >= 128) ? (b | 32'hFFFFFF00) : b;
         3'd4:    return b;
         3'd1:    return (h >= 32768) ? (h | 32'hFFFF0000) : h;
         3'd5:    return h;
         default: return word;
      endcase
   endfunction

   function automatic bit [3:0] m_be(bit w, bit [2:0] f, bit [31:0] a);
      if (!w) return 4'hF;
      if (f == 3'd0) return 4'(1 << (a % 4));
      if (f == 3'd1) return 4'(3 << (a % 4));
      return 4'hF;
   endfunction

   function automatic bit [31:0] m_wdata(bit [2:0] f, bit [31:0] wd);
      if (f == 3'd0) return (wd & 32'hFF) * 32'h01010101;
      if (f == 3'd1) return (wd & 32'hFFFF) * 32'h00010001;
      return wd;
   endfunction

   // observations from the last transaction
   int        obs_acc, obs_done_cyc;
   bit        obs_err, obs_stable, obs_we;
   bit [31:0] obs_rdata, obs_addr, obs_wdata;
   bit [3:0]  obs_be;

   task automatic run(input bit w, input bit [2:0] f, input bit [31:0] a, input bit [31:0] wd,
                      input int ready_at, input bit [31:0] word, input bit noise);
      int cyc = 1;
      @(negedge clk);
      req = 1'b1; we = w; funct = f; addr = a; wdata = wd;
      bus_ready = 1'b0; bus_rdata = $urandom;
      obs_acc = 0; obs_done_cyc = 0; obs_err = 1'b0; obs_stable = 1'b1;
      obs_rdata = 32'h0; obs_addr = 32'h0; obs_wdata = 32'h0; obs_be = 4'h0; obs_we = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         cyc++;
         req = 1'b0; bus_ready = 1'b0; bus_rdata = $urandom;
         if (noise) begin
            we = 1'($urandom); funct = 3'($urandom); addr = $urandom; wdata = $urandom;
         end
         if (done) begin
            obs_done_cyc = cyc; obs_err = err; obs_rdata = rdata;
            break;
         end
         if (bus_req) begin
            obs_acc++;
            if (obs_acc == 1) begin
               obs_addr = bus_addr; obs_be = bus_be; obs_wdata = bus_wdata; obs_we = bus_we;
            end else if (bus_addr !== obs_addr || bus_be !== obs_be ||
                         bus_wdata !== obs_wdata || bus_we !== obs_we) begin
               obs_stable = 1'b0;
            end
            if (noise) req = 1'b1;
            if (obs_acc == ready_at) begin
               bus_ready = 1'b1; bus_rdata = word;
            end
         end
      end
      n_cmp++;
      if (obs_done_cyc == 0) begin
         n_bad++;
         $display("FAIL done_bound: no done within 40 cycles (f=%0d a=%h)", f, a);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; req = 1'b0; we = 1'b0; funct = 3'd0; addr = 32'h0; wdata = 32'h0;
      bus_ready = 1'b0; bus_rdata = 32'h0;
      exp_rdata = 32'h0;
      repeat (2) @(negedge clk);
      n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0)     begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
      n_cmp++; if (err !== 1'b0)      begin n_bad++; $display("FAIL rst_err: got %b want 0", err); end
      n_cmp++; if (bus_req !== 1'b0)  begin n_bad++; $display("FAIL rst_bus_req: got %b want 0", bus_req); end
      n_cmp++; if (bus_we !== 1'b0)   begin n_bad++; $display("FAIL rst_bus_we: got %b want 0", bus_we); end
      n_cmp++; if (bus_be !== 4'h0)   begin n_bad++; $display("FAIL rst_bus_be: got %h want 0", bus_be); end
      n_cmp++; if (rdata !== 32'h0)   begin n_bad++; $display("FAIL rst_rdata: got %h want 0", rdata); end
      reset = 1'b0;
   endtask

   task automatic test_directed;
      // LB at byte 2, sign-extended
      run(1'b0, 3'd0, 32'h0000_1002, 32'h0, 1, 32'h12F4_5678, 1'b0);
      exp_rdata = 32'hFFFF_FFF4;
      n_cmp++; if (obs_be !== 4'hF)        begin n_bad++; $display("FAIL lb_be: got %h want f", obs_be); end
      n_cmp++; if (obs_done_cyc != 3)      begin n_bad++; $display("FAIL lb_latency: got %0d want 3", obs_done_cyc); end
      n_cmp++; if (obs_rdata !== exp_rdata) begin n_bad++; $display("FAIL lb_rdata: got %h want %h", obs_rdata, exp_rdata); end
      n_cmp++; if (obs_err !== 1'b0)       begin n_bad++; $display("FAIL lb_err: got %b want 0", obs_err); end
      n_cmp++; if (obs_addr !== 32'h1000)  begin n_bad++; $display("FAIL lb_addr: got %h want 1000", obs_addr); end
      // SH at upper half
      run(1'b1, 3'd1, 32'h0000_2002, 32'h0000_ABCD, 2, 32'h0, 1'b0);
      n_cmp++; if (obs_be !== 4'b1100)         begin n_bad++; $display("FAIL sh_be: got %b want 1100", obs_be); end
      n_cmp++; if (obs_wdata !== 32'hABCDABCD) begin n_bad++; $display("FAIL sh_wdata: got %h want abcdabcd", obs_wdata); end
      n_cmp++; if (obs_we !== 1'b1)            begin n_bad++; $display("FAIL sh_we: got %b want 1", obs_we); end
      n_cmp++; if (obs_done_cyc != 4)          begin n_bad++; $display("FAIL sh_latency: got %0d want 4", obs_done_cyc); end
      n_cmp++; if (obs_rdata !== exp_rdata)    begin n_bad++; $display("FAIL sh_rdata: got %h want %h", obs_rdata, exp_rdata); end
      // misaligned LW
      run(1'b0, 3'd2, 32'h0000_3001, 32'h0, 1, 32'h0, 1'b0);
      n_cmp++; if (obs_acc != 0)            begin n_bad++; $display("FAIL lw_mis_bus: got %0d cycles want 0", obs_acc); end
      n_cmp++; if (obs_done_cyc != 2)       begin n_bad++; $display("FAIL lw_mis_latency: got %0d want 2", obs_done_cyc); end
      n_cmp++; if (obs_err !== 1'b1)        begin n_bad++; $display("FAIL lw_mis_err: got %b want 1", obs_err); end
      n_cmp++; if (obs_rdata !== exp_rdata) begin n_bad++; $display("FAIL lw_mis_rdata: got %h want %h", obs_rdata, exp_rdata); end
   endtask

   task automatic test_timeout;
      bit [31:0] word = 32'h8765_4321;
      run(1'b0, 3'd5, 32'h0000_4002, 32'h0, 0, word, 1'b0);
      n_cmp++; if (obs_acc != 15)           begin n_bad++; $display("FAIL to_cycles: got %0d want 15", obs_acc); end
      n_cmp++; if (obs_stable !== 1'b1)     begin n_bad++; $display("FAIL to_stable: got %b want 1", obs_stable); end
      n_cmp++; if (obs_err !== 1'b1)        begin n_bad++; $display("FAIL to_err: got %b want 1", obs_err); end
      n_cmp++; if (obs_done_cyc != 17)      begin n_bad++; $display("FAIL to_latency: got %0d want 17", obs_done_cyc); end
      n_cmp++; if (obs_rdata !== exp_rdata) begin n_bad++; $display("FAIL to_rdata: got %h want %h", obs_rdata, exp_rdata); end
      // ready on the last allowed cycle wins over the timeout
      run(1'b0, 3'd5, 32'h0000_4002, 32'h0, 15, word, 1'b0);
      exp_rdata = m_load(3'd5, 32'h0000_4002, word);
      n_cmp++; if (obs_acc != 15)           begin n_bad++; $display("FAIL to15_cycles: got %0d want 15", obs_acc); end
      n_cmp++; if (obs_err !== 1'b0)        begin n_bad++; $display("FAIL to15_err: got %b want 0", obs_err); end
      n_cmp++; if (obs_rdata !== exp_rdata) begin n_bad++; $display("FAIL to15_rdata: got %h want %h", obs_rdata, exp_rdata); end
   endtask

   task automatic test_reset_mid;
      int extra_done = 0;
      int extra_req = 0;
      bit [31:0] wd = $urandom;
      @(negedge clk);
      req = 1'b1; we = 1'b0; funct = 3'd2; addr = 32'h0000_5000; bus_ready = 1'b0;
      @(negedge clk);
      req = 1'b0;
      n_cmp++; if (bus_req !== 1'b1) begin n_bad++; $display("FAIL rm_started: got %b want 1", bus_req); end
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      exp_rdata = 32'h0;
      n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL rm_bus_req: got %b want 0", bus_req); end
      n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL rm_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0)    begin n_bad++; $display("FAIL rm_done: got %b want 0", done); end
      n_cmp++; if (rdata !== 32'h0)  begin n_bad++; $display("FAIL rm_rdata: got %h want 0", rdata); end
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (done) extra_done++;
         if (bus_req) extra_req++;
      end
      n_cmp++; if (extra_done != 0) begin n_bad++; $display("FAIL rm_no_done: got %0d want 0", extra_done); end
      n_cmp++; if (extra_req != 0)  begin n_bad++; $display("FAIL rm_no_bus: got %0d want 0", extra_req); end
      run(1'b1, 3'd2, 32'h0000_6004, wd, 1, 32'h0, 1'b0);
      n_cmp++; if (obs_be !== 4'hF)   begin n_bad++; $display("FAIL rm_sw_be: got %h want f", obs_be); end
      n_cmp++; if (obs_wdata !== wd)  begin n_bad++; $display("FAIL rm_sw_wdata: got %h want %h", obs_wdata, wd); end
      n_cmp++; if (obs_err !== 1'b0)  begin n_bad++; $display("FAIL rm_sw_err: got %b want 0", obs_err); end
      n_cmp++; if (obs_done_cyc != 3) begin n_bad++; $display("FAIL rm_sw_latency: got %0d want 3", obs_done_cyc); end
   endtask

   task automatic test_back_to_back;
      int extra_done = 0;
      bit [31:0] word = $urandom;
      run(1'b0, 3'd1, 32'h0000_7006, 32'h0, 4, word, 1'b1);
      exp_rdata = m_load(3'd1, 32'h0000_7006, word);
      n_cmp++; if (obs_stable !== 1'b1)     begin n_bad++; $display("FAIL b2b_stable: got %b want 1", obs_stable); end
      n_cmp++; if (obs_addr !== 32'h7004)   begin n_bad++; $display("FAIL b2b_addr: got %h want 7004", obs_addr); end
      n_cmp++; if (obs_rdata !== exp_rdata) begin n_bad++; $display("FAIL b2b_rdata: got %h want %h", obs_rdata, exp_rdata); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (done) extra_done++;
      end
      n_cmp++; if (extra_done != 0) begin n_bad++; $display("FAIL b2b_one_done: got %0d extra want 0", extra_done); end
   endtask

   task automatic test_random;
      for (int i = 0; i < 60; i++) begin
         bit        w   = 1'($urandom);
         bit [2:0]  f   = 3'($urandom);
         bit [31:0] a   = $urandom;
         bit [31:0] wd  = $urandom;
         bit [31:0] wrd = $urandom;
         int        ra  = $urandom_range(1, 5);
         if (i % 2 == 0) f = (i % 4 == 0) ? 3'd0 : 3'($urandom_range(0, 2));
         run(w, f, a, wd, ra, wrd, 1'($urandom));
         if (!m_legal(w, f, a)) begin
            n_cmp++; if (obs_acc != 0 || obs_done_cyc != 2 || obs_err !== 1'b1) begin
               n_bad++; $display("FAIL rnd_reject[%0d]: got acc=%0d cyc=%0d err=%b want 0/2/1", i, obs_acc, obs_done_cyc, obs_err);
            end
         end else begin
            if (!w) exp_rdata = m_load(f, a, wrd);
            n_cmp++; if (obs_acc != ra || obs_done_cyc != ra + 2 || obs_err !== 1'b0) begin
               n_bad++; $display("FAIL rnd_timing[%0d]: got acc=%0d cyc=%0d err=%b want %0d/%0d/0", i, obs_acc, obs_done_cyc, obs_err, ra, ra + 2);
            end
            n_cmp++; if (obs_addr !== (a & 32'hFFFF_FFFC) || obs_we !== w || obs_be !== m_be(w, f, a)) begin
               n_bad++; $display("FAIL rnd_bus[%0d]: got addr=%h we=%b be=%h want %h/%b/%h", i, obs_addr, obs_we, obs_be, a & 32'hFFFF_FFFC, w, m_be(w, f, a));
            end
            if (w) begin
               n_cmp++; if (obs_wdata !== m_wdata(f, wd)) begin
                  n_bad++; $display("FAIL rnd_wdata[%0d]: got %h want %h", i, obs_wdata, m_wdata(f, wd));
               end
            end
         end
         n_cmp++; if (obs_rdata !== exp_rdata) begin
            n_bad++; $display("FAIL rnd_rdata[%0d]: got %h want %h", i, obs_rdata, exp_rdata);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
